// File: rtl/match_sweep_ctrl_pkg.sv
// Shared types and constants for the board match sweeper: colour width, state encoding, cell indexing.
// Latency: none. Backpressure: none.
package match_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;
  localparam int CW       = 3;

  localparam logic [CW-1:0] EMPTY = '0;

`ifdef MATCH_SWEEP_GRAVITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CLEAR,
    ST_FALL,
    ST_DONE
  } sweep_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CLEAR,
    ST_DONE
  } sweep_state_t;
`endif

  // Row-major flat position of cell (r,c); row 0 is the top of the board.
  function automatic int cell_idx(input int r, input int c, input int cols = COLS_DEF);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/match_sweep_ctrl_if.sv
// Request/result bundle between the board owner (master) and the sweeper (slave).
// Latency: none. Backpressure: start is ignored by the slave while busy.
interface match_sweep_ctrl_if
  import match_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) ();

  logic                      start;
  logic [ROWS*COLS*CW-1:0]   board_in;
  logic                      busy;
  logic                      done;
  logic [ROWS*COLS*CW-1:0]   board_out;
  logic [ROWS*COLS-1:0]      clear_mask;
  logic [7:0]                clear_count;
  logic                      any_match;

  modport master (
    output start, board_in,
    input  busy, done, board_out, clear_mask, clear_count, any_match
  );

  modport slave (
    input  start, board_in,
    output busy, done, board_out, clear_mask, clear_count, any_match
  );

endinterface

// File: rtl/match_sweep_ctrl_run_detect.sv
// Three-cell run detector: hit when all three colours are equal and non-empty.
// Latency: combinational. Backpressure: none.
module match_run_detect
  import match_pkg::*;
(
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] c,
  output logic          hit
);

  assign hit = (a != EMPTY) && (a == b) && (a == c);

endmodule

// File: rtl/match_sweep_ctrl.sv
// Full-board run-of-3 sweep and clear; optional column gravity with cascade via MATCH_SWEEP_GRAVITY_EN.
// Latency: ROWS*COLS+2 cycles start->done per pass; start is ignored (not queued) while busy.
module match_sweep_ctrl
  import match_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  match_sweep_ctrl_if.slave  sw
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef logic [IW-1:0] idx_t;

  sweep_state_t  state;
  logic [CW-1:0] cells [N];
  logic [N-1:0]  mask;
  idx_t          idx;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    count_q;
  logic          any_q;
  logic [N-1:0]  mask_out_q;

  // Neighbour addresses fold back onto the current cell when out of range;
  // the h_ok/v_ok qualifiers discard those hits.
  int            row;
  int            col;
  logic          h_ok;
  logic          v_ok;
  idx_t          ph1, ph2, pv1, pv2;
  logic          hit_h;
  logic          hit_v;
  logic [N-1:0]  scan_bits;

  match_run_detect u_hdet (
    .a   (cells[idx]),
    .b   (cells[ph1]),
    .c   (cells[ph2]),
    .hit (hit_h)
  );

  match_run_detect u_vdet (
    .a   (cells[idx]),
    .b   (cells[pv1]),
    .c   (cells[pv2]),
    .hit (hit_v)
  );

  always_comb begin
    row  = int'(idx) / COLS;
    col  = int'(idx) % COLS;
    h_ok = (col + 2 < COLS);
    v_ok = (row + 2 < ROWS);
    ph1  = h_ok ? idx_t'(cell_idx(row, col + 1, COLS)) : idx;
    ph2  = h_ok ? idx_t'(cell_idx(row, col + 2, COLS)) : idx;
    pv1  = v_ok ? idx_t'(cell_idx(row + 1, col, COLS)) : idx;
    pv2  = v_ok ? idx_t'(cell_idx(row + 2, col, COLS)) : idx;
    scan_bits = '0;
    if (hit_h && h_ok) begin
      scan_bits[idx] = 1'b1;
      scan_bits[ph1] = 1'b1;
      scan_bits[ph2] = 1'b1;
    end
    if (hit_v && v_ok) begin
      scan_bits[idx] = 1'b1;
      scan_bits[pv1] = 1'b1;
      scan_bits[pv2] = 1'b1;
    end
  end

  logic [15:0] pop;
  logic [15:0] sum;
  logic [7:0]  count_nxt;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + 16'(mask[i]);
    end
    sum       = 16'(count_q) + pop;
    count_nxt = (sum > 16'd255) ? 8'hFF : sum[7:0];
  end

`ifdef MATCH_SWEEP_GRAVITY_EN
  logic [CW-1:0] fall_cells [N];
  logic [N-1:0]  moved;
  logic          fall_any;

  // One-row drop per cycle: a tile leaves its cell when the cell below is empty.
  always_comb begin
    moved = '0;
    for (int i = 0; i < N - COLS; i++) begin
      moved[i] = (cells[i] != EMPTY) && (cells[i + COLS] == EMPTY);
    end
    for (int i = 0; i < N; i++) begin
      fall_cells[i] = moved[i] ? EMPTY : cells[i];
      if (i >= COLS) begin
        if (moved[i - COLS]) begin
          fall_cells[i] = cells[i - COLS];
        end
      end
    end
    fall_any = |moved;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mask       <= '0;
      idx        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      any_q      <= 1'b0;
      mask_out_q <= '0;
      for (int i = 0; i < N; i++) begin
        cells[i] <= EMPTY;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (sw.start) begin
            for (int i = 0; i < N; i++) begin
              cells[i] <= sw.board_in[i*CW +: CW];
            end
            mask       <= '0;
            count_q    <= '0;
            any_q      <= 1'b0;
            mask_out_q <= '0;
            idx        <= '0;
            busy_q     <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          mask <= mask | scan_bits;
          if (idx == idx_t'(N - 1)) begin
            state <= ST_CLEAR;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_CLEAR: begin
          for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
              cells[i] <= EMPTY;
            end
          end
          count_q <= count_nxt;
          any_q   <= any_q | (|mask);
          // An empty cascade pass leaves the last useful mask visible.
          if (|mask) begin
            mask_out_q <= mask;
          end
`ifdef MATCH_SWEEP_GRAVITY_EN
          if (|mask) begin
            state <= ST_FALL;
          end else begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
`else
          state  <= ST_DONE;
          done_q <= 1'b1;
`endif
        end
`ifdef MATCH_SWEEP_GRAVITY_EN
        ST_FALL: begin
          if (fall_any) begin
            for (int i = 0; i < N; i++) begin
              cells[i] <= fall_cells[i];
            end
          end else begin
            mask  <= '0;
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
`endif
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      sw.board_out[i*CW +: CW] = cells[i];
    end
  end

  assign sw.busy        = busy_q;
  assign sw.done        = done_q;
  assign sw.clear_mask  = mask_out_q;
  assign sw.clear_count = count_q;
  assign sw.any_match   = any_q;

endmodule

// File: tb/tb_match_sweep_ctrl.sv
// Directed bench for match_sweep_ctrl with a result scoreboard; gravity expectations follow MATCH_SWEEP_GRAVITY_EN.
module tb_match_sweep_ctrl;
  import match_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int BW   = N * CW;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  match_sweep_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) sw ();

  match_sweep_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw)
  );

  typedef struct {
    logic [7:0]    count;
    logic          any;
    logic [N-1:0]  mask;
    logic [BW-1:0] board;
    int            lat;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [BW-1:0] brd;
  logic [BW-1:0] exp_brd;
  logic [N-1:0]  m;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void put(input int r, input int c, input logic [CW-1:0] v);
    brd[(r*COLS+c)*CW +: CW] = v;
  endfunction

  function automatic void mark(input int r, input int c);
    m[r*COLS+c] = 1'b1;
    exp_brd[(r*COLS+c)*CW +: CW] = '0;
  endfunction

  // Background cycling through three colours along both axes: never three equal in a line.
  function automatic void bg(input int base);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        put(r, c, CW'(base + (r + 2*c) % 3));
      end
    end
  endfunction

  function automatic void push(input logic [7:0] cnt, input logic any, input int lat);
    exp_t e;
    e.count = cnt;
    e.any   = any;
    e.mask  = m;
    e.board = exp_brd;
    e.lat   = lat;
    sb.push_back(e);
  endfunction

  // Launch a sweep on brd; optionally re-pulse start n edges after acceptance.
  task automatic run(input string tag, input int repulse);
    exp_t e;
    int   n;
    logic got;
    sw.board_in = brd;
    @(negedge clk);
    sw.start = 1'b1;
    @(posedge clk);
    #1;
    sw.start = 1'b0;
    check({tag, "_busy_up"}, BW'(sw.busy), BW'(1));
    got = 1'b0;
    n   = 0;
    while (!got && n < 3000) begin
      n++;
      sw.start = (n == repulse);
      @(posedge clk);
      #1;
      got = sw.done;
    end
    sw.start = 1'b0;
    check({tag, "_done_seen"}, BW'(got), BW'(1));
    if (got) begin
      e = sb.pop_front();
      if (e.lat >= 0) check({tag, "_latency"}, BW'(n), BW'(e.lat));
      check({tag, "_busy_at_done"}, BW'(sw.busy), BW'(1));
      check({tag, "_count"}, BW'(sw.clear_count), BW'(e.count));
      check({tag, "_any"}, BW'(sw.any_match), BW'(e.any));
      check({tag, "_mask"}, BW'(sw.clear_mask), BW'(e.mask));
      check({tag, "_board"}, sw.board_out, e.board);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, BW'(sw.done), BW'(0));
      check({tag, "_busy_down"}, BW'(sw.busy), BW'(0));
      check({tag, "_count_hold"}, BW'(sw.clear_count), BW'(e.count));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, BW'(sw.busy), BW'(0));
    check({tag, "_done"}, BW'(sw.done), BW'(0));
    check({tag, "_count"}, BW'(sw.clear_count), BW'(0));
    check({tag, "_any"}, BW'(sw.any_match), BW'(0));
    check({tag, "_mask"}, BW'(sw.clear_mask), BW'(0));
    check({tag, "_board"}, sw.board_out, BW'(0));
  endtask

  initial begin
    int   saw_done;
    rst_n       = 1'b0;
    sw.start    = 1'b0;
    sw.board_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Empty board: no matches, 65 edges from acceptance to done.
    brd = '0; exp_brd = '0; m = '0;
    push(8'd0, 1'b0, 65);
    run("empty", 0);

    // Single horizontal run of 5s in row 3; start re-pulsed mid-scan must be ignored.
    brd = '0; m = '0;
    bg(1);
    for (int c = 2; c <= 4; c++) put(3, c, 3'd5);
    exp_brd = brd;
    for (int c = 2; c <= 4; c++) mark(3, c);
    push(8'd3, 1'b1, 65);
    run("row3", 10);

    // L shape shares its corner (5 cells, not 6) plus a separate 4-run on the bottom row.
    brd = '0; m = '0;
    bg(4);
    for (int c = 0; c <= 2; c++) put(0, c, 3'd2);
    put(1, 0, 3'd2);
    put(2, 0, 3'd2);
    for (int c = 0; c <= 3; c++) put(7, c, 3'd7);
    exp_brd = brd;
    for (int c = 0; c <= 2; c++) mark(0, c);
    mark(1, 0);
    mark(2, 0);
    for (int c = 0; c <= 3; c++) mark(7, c);
    push(8'd9, 1'b1, 65);
    run("lshape", 0);

    // Reset while scanning idx 20: everything returns to zero and stays idle.
    brd = '0;
    bg(1);
    for (int c = 2; c <= 4; c++) put(3, c, 3'd5);
    sw.board_in = brd;
    @(negedge clk);
    sw.start = 1'b1;
    @(posedge clk);
    #1;
    sw.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sw.done || sw.busy) saw_done++;
    end
    check("idle_after_reset", BW'(saw_done), BW'(0));

    // Column 0: 3-run of colour 3 with colour-1 tiles that only line up after falling.
    brd = '0; m = '0;
    put(0, 0, 3'd2);
    put(2, 0, 3'd1);
    put(3, 0, 3'd1);
    for (int r = 4; r <= 6; r++) put(r, 0, 3'd3);
    put(7, 0, 3'd1);
`ifdef MATCH_SWEEP_GRAVITY_EN
    exp_brd = '0;
    exp_brd[(7*COLS+0)*CW +: CW] = 3'd2;
    for (int r = 5; r <= 7; r++) m[r*COLS] = 1'b1;
    push(8'd6, 1'b1, -1);
`else
    exp_brd = brd;
    for (int r = 4; r <= 6; r++) mark(r, 0);
    push(8'd3, 1'b1, 65);
`endif
    run("cascade", 0);

    check("sb_empty", BW'(sb.size()), BW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
